// File: rtl/hall_call_panel.sv
// Hall-call button front end: synchronise, debounce and latch 12 buttons until the controller clears them.
// Optional STUCK_DETECT_EN adds per-button hold timers that drop and block calls from jammed buttons.
module hall_call_panel #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int STUCK_CYCLES    = 500000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] btn_raw,
   input  logic [11:0] clr,
   output logic [11:0] req,
   output logic [11:0] lamp,
   output logic [11:0] new_req,
   output logic [3:0]  pending_cnt,
   output logic [11:0] stuck
);

   localparam int NB = 12;
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NB-1:0] r_s1;
   logic [NB-1:0] r_s2;
   logic [NB-1:0] w_stable;
   logic [NB-1:0] w_press;
   logic [NB-1:0] w_req;
   logic [NB-1:0] w_new_req;
   logic [NB-1:0] w_stuck;
   logic [NB-1:0] w_stuck_hit;
   logic [3:0]    w_pop;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= btn_raw;
         r_s2 <= r_s1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_bit
         logic [CW-1:0] r_cnt;
         logic          r_stable;
         logic          r_req;
         logic          r_new_req;
         logic          w_mismatch;
         logic          w_accept;

         assign w_mismatch = r_s2[gi] ^ r_stable;
         assign w_accept   = w_mismatch && (r_cnt == DB_LAST);
         // A press is the edge where a debounced 0->1 change is accepted.
         assign w_press[gi] = w_accept && r_s2[gi];

         always_ff @(posedge clk) begin
            if (reset) begin
               r_cnt    <= '0;
               r_stable <= 1'b0;
            end else if (w_mismatch) begin
               if (w_accept) begin
                  r_stable <= r_s2[gi];
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end else begin
               r_cnt <= '0;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               r_req     <= 1'b0;
               r_new_req <= 1'b0;
            end else begin
               r_new_req <= 1'b0;
               if (clr[gi] || w_stuck_hit[gi]) begin
                  r_req <= 1'b0;
               end else if (w_press[gi] && !r_req && !w_stuck[gi]) begin
                  r_req     <= 1'b1;
                  r_new_req <= 1'b1;
               end
            end
         end

         assign w_stable[gi]  = r_stable;
         assign w_req[gi]     = r_req;
         assign w_new_req[gi] = r_new_req;

`ifdef STUCK_DETECT_EN
         localparam int HW = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES + 1) : 1;
         localparam logic [HW-1:0] HOLD_LAST = HW'(STUCK_CYCLES - 1);
         localparam logic [HW-1:0] HOLD_MAX  = HW'(STUCK_CYCLES);

         logic [HW-1:0] r_hold;
         logic          r_stuck;
         logic          w_fall;

         assign w_fall          = w_accept && !r_s2[gi];
         assign w_stuck_hit[gi] = r_stable && !r_stuck && (r_hold == HOLD_LAST);

         // Hold count saturates so a jammed button is flagged only once.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_hold  <= '0;
               r_stuck <= 1'b0;
            end else begin
               if (!r_stable) begin
                  r_hold <= '0;
               end else if (r_hold != HOLD_MAX) begin
                  r_hold <= r_hold + HW'(1);
               end
               if (w_fall) begin
                  r_stuck <= 1'b0;
               end else if (w_stuck_hit[gi]) begin
                  r_stuck <= 1'b1;
               end
            end
         end

         assign w_stuck[gi] = r_stuck;
`else
         assign w_stuck_hit[gi] = 1'b0;
         assign w_stuck[gi]     = 1'b0;
`endif
      end
   endgenerate

`ifndef STUCK_DETECT_EN
   if (STUCK_CYCLES < 1) begin : g_bad_stuck
      $error("STUCK_CYCLES must be at least 1");
   end
`endif

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NB; i++) begin
         w_pop = w_pop + {3'b000, w_req[i]};
      end
   end

   assign req         = w_req;
   assign lamp        = w_req;
   assign new_req     = w_new_req;
   assign stuck       = w_stuck;
   assign pending_cnt = w_pop;

endmodule

// File: tb/tb_hall_call_panel.sv
// Directed bench for hall_call_panel with DEBOUNCE_CYCLES=4 and STUCK_CYCLES=20.
// Stuck-detect expectations switch with STUCK_DETECT_EN.
module tb_hall_call_panel;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] btn_raw;
   logic [11:0] clr;
   logic [11:0] req;
   logic [11:0] lamp;
   logic [11:0] new_req;
   logic [3:0]  pending_cnt;
   logic [11:0] stuck;

   int n_checks = 0;
   int n_fail   = 0;

   hall_call_panel #(
      .DEBOUNCE_CYCLES(4),
      .STUCK_CYCLES   (20)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .clr        (clr),
      .req        (req),
      .lamp       (lamp),
      .new_req    (new_req),
      .pending_cnt(pending_cnt),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      btn_raw = '0;
      clr     = '0;
      tick(2);
      reset = 1'b0;
      tick(1);
      n_checks++;
      if (req !== 12'h000) begin n_fail++; $display("FAIL reset_req actual=%h required=000", req); end
      n_checks++;
      if (new_req !== 12'h000) begin n_fail++; $display("FAIL reset_new_req actual=%h required=000", new_req); end
      n_checks++;
      if (pending_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt actual=%0d required=0", pending_cnt); end
      n_checks++;
      if (stuck !== 12'h000) begin n_fail++; $display("FAIL reset_stuck actual=%h required=000", stuck); end
      $display("reset: req=%h new_req=%h cnt=%0d stuck=%h", req, new_req, pending_cnt, stuck);
   endtask

   task automatic test_latency;
      btn_raw[0] = 1'b1;
      tick(5);
      n_checks++;
      if (req[0] !== 1'b0) begin n_fail++; $display("FAIL lat_early actual=%b required=0", req[0]); end
      tick(1);
      n_checks++;
      if (req[0] !== 1'b1) begin n_fail++; $display("FAIL lat_req actual=%b required=1", req[0]); end
      n_checks++;
      if (new_req !== 12'h001) begin n_fail++; $display("FAIL lat_new actual=%h required=001", new_req); end
      n_checks++;
      if (pending_cnt !== 4'd1) begin n_fail++; $display("FAIL lat_cnt actual=%0d required=1", pending_cnt); end
      n_checks++;
      if (lamp !== 12'h001) begin n_fail++; $display("FAIL lat_lamp actual=%h required=001", lamp); end
      tick(1);
      n_checks++;
      if (new_req[0] !== 1'b0) begin n_fail++; $display("FAIL lat_new_drop actual=%b required=0", new_req[0]); end
      btn_raw[0] = 1'b0;
      tick(8);
      n_checks++;
      if (req[0] !== 1'b1) begin n_fail++; $display("FAIL lat_release_hold actual=%b required=1", req[0]); end
      clr[0] = 1'b1;
      tick(1);
      clr[0] = 1'b0;
      n_checks++;
      if (req !== 12'h000) begin n_fail++; $display("FAIL lat_clear actual=%h required=000", req); end
      $display("latency: req=%h cnt=%0d", req, pending_cnt);
   endtask

   task automatic test_bounce;
      int seen = 0;
      btn_raw[3] = 1'b1;
      tick(3);
      btn_raw[3] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (new_req[3] || req[3]) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL short_press actual=%0d cycles with req/new_req required=0", seen); end
      // Raw pattern 1,0,1,1,1,1 then held.
      btn_raw[3] = 1'b1; tick(1);
      btn_raw[3] = 1'b0; tick(1);
      btn_raw[3] = 1'b1; tick(5);
      n_checks++;
      if (req[3] !== 1'b0) begin n_fail++; $display("FAIL bounce_early actual=%b required=0", req[3]); end
      tick(1);
      n_checks++;
      if (req[3] !== 1'b1 || new_req[3] !== 1'b1) begin
         n_fail++; $display("FAIL bounce_latch actual req=%b new=%b required 1/1", req[3], new_req[3]);
      end
      btn_raw[3] = 1'b0;
      tick(8);
      clr[3] = 1'b1; tick(1); clr[3] = 1'b0;
      $display("bounce: req=%h", req);
   endtask

   task automatic test_clear;
      btn_raw[5] = 1'b1;
      tick(7);
      btn_raw[5] = 1'b0;
      tick(8);
      n_checks++;
      if (req !== 12'h020 || pending_cnt !== 4'd1) begin
         n_fail++; $display("FAIL clr_pre actual req=%h cnt=%0d required 020/1", req, pending_cnt);
      end
      clr[5] = 1'b1; tick(1); clr[5] = 1'b0;
      n_checks++;
      if (req !== 12'h000 || pending_cnt !== 4'd0) begin
         n_fail++; $display("FAIL clr_post actual req=%h cnt=%0d required 000/0", req, pending_cnt);
      end
      clr[7] = 1'b1; tick(1); clr[7] = 1'b0;
      n_checks++;
      if (req !== 12'h000 || new_req !== 12'h000) begin
         n_fail++; $display("FAIL clr_idle actual req=%h new=%h required 000/000", req, new_req);
      end
      $display("clear: req=%h cnt=%0d", req, pending_cnt);
   endtask

   task automatic test_clear_vs_press;
      btn_raw[2] = 1'b1;
      tick(5);
      clr[2] = 1'b1; tick(1); clr[2] = 1'b0;
      n_checks++;
      if (req[2] !== 1'b0 || new_req[2] !== 1'b0) begin
         n_fail++; $display("FAIL cvp_same actual req=%b new=%b required 0/0", req[2], new_req[2]);
      end
      tick(10);
      n_checks++;
      if (req[2] !== 1'b0) begin n_fail++; $display("FAIL cvp_held actual=%b required=0", req[2]); end
      btn_raw[2] = 1'b0;
      tick(8);
      btn_raw[2] = 1'b1;
      tick(6);
      n_checks++;
      if (req[2] !== 1'b1 || new_req[2] !== 1'b1) begin
         n_fail++; $display("FAIL cvp_repress actual req=%b new=%b required 1/1", req[2], new_req[2]);
      end
      btn_raw[2] = 1'b0;
      tick(8);
      clr[2] = 1'b1; tick(1); clr[2] = 1'b0;
      $display("clear_vs_press: req=%h", req);
   endtask

   task automatic test_all_and_reset;
      btn_raw = 12'hFFF;
      tick(6);
      n_checks++;
      if (req !== 12'hFFF || pending_cnt !== 4'd12) begin
         n_fail++; $display("FAIL all_set actual req=%h cnt=%0d required FFF/12", req, pending_cnt);
      end
      n_checks++;
      if (new_req !== 12'hFFF) begin n_fail++; $display("FAIL all_new actual=%h required=FFF", new_req); end
      tick(1);
      reset = 1'b1; tick(1); reset = 1'b0;
      n_checks++;
      if (req !== 12'h000 || pending_cnt !== 4'd0 || new_req !== 12'h000) begin
         n_fail++; $display("FAIL mid_reset actual req=%h cnt=%0d new=%h required 000/0/000", req, pending_cnt, new_req);
      end
      tick(5);
      n_checks++;
      if (req !== 12'h000) begin n_fail++; $display("FAIL post_reset_early actual=%h required=000", req); end
      tick(1);
      n_checks++;
      if (req !== 12'hFFF || new_req !== 12'hFFF) begin
         n_fail++; $display("FAIL post_reset_relatch actual req=%h new=%h required FFF/FFF", req, new_req);
      end
      btn_raw = '0;
      tick(8);
      clr = 12'hFFF; tick(1); clr = '0;
      n_checks++;
      if (pending_cnt !== 4'd0) begin n_fail++; $display("FAIL all_clear actual=%0d required=0", pending_cnt); end
      $display("all_and_reset: req=%h cnt=%0d", req, pending_cnt);
   endtask

   task automatic test_hold;
      btn_raw[10] = 1'b1;
      tick(25);
      n_checks++;
      if (req[10] !== 1'b1 || stuck[10] !== 1'b0) begin
         n_fail++; $display("FAIL hold_pre actual req=%b stuck=%b required 1/0", req[10], stuck[10]);
      end
      tick(1);
`ifdef STUCK_DETECT_EN
      n_checks++;
      if (stuck[10] !== 1'b1 || req[10] !== 1'b0) begin
         n_fail++; $display("FAIL stuck_set actual stuck=%b req=%b required 1/0", stuck[10], req[10]);
      end
`else
      n_checks++;
      if (stuck !== 12'h000 || req[10] !== 1'b1) begin
         n_fail++; $display("FAIL hold_no_stuck actual stuck=%h req=%b required 000/1", stuck, req[10]);
      end
`endif
      btn_raw[10] = 1'b0;
      tick(8);
      n_checks++;
      if (stuck !== 12'h000) begin n_fail++; $display("FAIL stuck_release actual=%h required=000", stuck); end
`ifdef STUCK_DETECT_EN
      btn_raw[10] = 1'b1;
      tick(6);
      n_checks++;
      if (req[10] !== 1'b1) begin n_fail++; $display("FAIL stuck_repress actual=%b required=1", req[10]); end
      btn_raw[10] = 1'b0;
      tick(8);
`endif
      clr[10] = 1'b1; tick(1); clr[10] = 1'b0;
      $display("hold: req=%h stuck=%h", req, stuck);
   endtask

   initial begin
      reset   = 1'b1;
      btn_raw = '0;
      clr     = '0;
      @(negedge clk);
      test_reset();
      test_latency();
      test_bounce();
      test_clear();
      test_clear_vs_press();
      test_all_and_reset();
      test_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hall_call_panel.md
Name: hall_call_panel

Overview:
- Front end for the 12 hall-call buttons: up on floors 1-6, down on floors 2-7.
- Synchronises and debounces the raw pushbuttons, then latches each press as a pending request that feeds the elevator controller's floor-button input.
- The request clears only when the controller pulses the matching clear bit after a car serves that call; the latched requests also drive the button lamps.

Parameters:
DEBOUNCE_CYCLES, 200000, consecutive stable cycles needed to accept a level change (2 ms at 100 MHz); legal range >= 1
STUCK_CYCLES, 500000000, hold time after which a pressed button is declared stuck (used only with STUCK_DETECT_EN)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
btn_raw  input  12  asynchronous raw buttons, 1 = pressed; bit 2k = up of floor k+1 (k=0..5), bit 2k+1 = down of floor k+2
clr  input  12  per-bit one-cycle clear from the controller, same bit mapping
req  output  12  latched pending hall calls to the controller, same mapping
lamp  output  12  button lamps; equal to req
new_req  output  12  one-cycle pulse on the cycle a bit of req first rises
pending_cnt  output  4  combinational popcount of req, 0..12
stuck  output  12  button declared stuck (0 without STUCK_DETECT_EN)

Behaviour:
- Reset (synchronous, dominant over everything): sync stages, debounced state, counters, req, new_req and stuck all go to 0; pending_cnt reads 0.
- Synchroniser: two flops per bit (s1 <= btn_raw, s2 <= s1).
- Debounce, per bit:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If s2 != stable: cnt <= cnt+1; when cnt == DEBOUNCE_CYCLES-1, stable <= s2 and cnt <= 0.
  - If s2 == stable: cnt <= 0, so any mismatch run shorter than DEBOUNCE_CYCLES is discarded.
- Press event: stable goes 0->1 at an edge.
- Latency: btn_raw first sampled high at edge 1, held steady -> req bit and new_req bit high after edge 2+DEBOUNCE_CYCLES.
- Latch rules, per bit, evaluated each edge:
  - clr=1 -> req <= 0. Clear wins over a same-cycle press event; that press is lost.
  - else press event -> req <= 1 and new_req <= 1 for exactly one cycle. If req is already 1, req stays 1 and new_req stays 0.
  - else req holds.
- Re-press rules:
  - A button still held after a clear does not re-latch; it must release (stable -> 0) and be pressed again.
  - Release never clears req.
- clr on a bit whose req is 0 has no effect.
- Any subset of the 12 bits may set and clear in the same cycle, independently.
- Reset mid-operation: all pending calls are lost. A button held through reset is seen as a fresh press once the debounce completes after reset release.
- No state machine beyond the per-bit stable/latched flags; there is no handshake other than clr.

Optional Feature:
- Macro STUCK_DETECT_EN.
- Defined:
  - Per-bit hold counter increments while stable=1 and resets to 0 when stable=0.
  - When the count reaches STUCK_CYCLES: stuck bit <= 1 and req bit <= 0 on that edge, and req for that bit cannot be set while stuck=1.
  - stuck clears on the edge stable goes 0; the next genuine press then latches normally.
- Undefined: no hold counters; stuck is tied to 0; held buttons remain latched until cleared by clr.

Test Plan:
- DEBOUNCE_CYCLES=4: btn_raw[0] high from edge 1 and held -> req[0]=1 and new_req[0]=1 after edge 6; new_req[0]=0 after edge 7; pending_cnt=1.
- DEBOUNCE_CYCLES=4: btn_raw[3] high for 3 cycles then low -> req[3] stays 0 and new_req[3] never pulses; bounce pattern 1,0,1,1,1,1 -> req[3] rises only after the final 4 stable cycles at s2.
- req[5]=1, button released, clr[5] pulsed one cycle -> req[5]=0 next cycle and pending_cnt decrements; clr[7] while req[7]=0 -> no change.
- Press event on bit 2 in the same cycle clr[2]=1 -> req[2]=0 and new_req[2]=0; hold continued -> still 0; release then press -> req[2]=1.
- Press all 12 bits simultaneously -> req=12'hFFF and pending_cnt=12. Then reset=1 for 1 cycle -> req=0, pending_cnt=0, new_req=0. Buttons still held -> req=12'hFFF again DEBOUNCE_CYCLES+2 edges after reset release.
- STUCK_DETECT_EN, STUCK_CYCLES=20, DEBOUNCE_CYCLES=4: hold bit 10 -> req[10] set, then after 20 stable-high cycles stuck[10]=1 and req[10]=0. Release -> stuck[10]=0. Re-press -> req[10]=1.
